// File: rtl/register_file_mp.sv
// Multi-port register file: two combinational read ports, two write-back ports (wb1 has priority).
// Optional producer scoreboard is compiled in with `define RF_SCOREBOARD_EN.
module register_file_mp #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb0_en,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_en,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0] wb1_data,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
`ifdef RF_SCOREBOARD_EN
  ,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              rs_busy,
  output logic              rt_busy
`endif
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;

  // A write port is effective unless it targets the hardwired zero register.
  logic wb0_live, wb1_live;
  assign wb0_live = wb0_en && !(ZERO_REG && (wb0_addr == '0));
  assign wb1_live = wb1_en && !(ZERO_REG && (wb1_addr == '0));

  always_comb begin
    regs_d = regs_q;
    if (wb0_live) regs_d[wb0_addr] = wb0_data;
    if (wb1_live) regs_d[wb1_addr] = wb1_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0]               addr,
    input logic [NREG-1:0][DATA_W-1:0]     regs,
    input logic                            w0_live,
    input logic [ADDR_W-1:0]               w0_addr,
    input logic [DATA_W-1:0]               w0_data,
    input logic                            w1_live,
    input logic [ADDR_W-1:0]               w1_addr,
    input logic [DATA_W-1:0]               w1_data
  );
    logic [DATA_W-1:0] val;
    val = regs[addr];
    if (BYPASS) begin
      if (w1_live && (w1_addr == addr)) begin
        val = w1_data;
      end else if (w0_live && (w0_addr == addr)) begin
        val = w0_data;
      end
    end
    if (ZERO_REG && (addr == '0)) val = '0;
    return val;
  endfunction

  always_comb begin
    rs_data = read_port(rs, regs_q, wb0_live, wb0_addr, wb0_data, wb1_live, wb1_addr, wb1_data);
    rt_data = read_port(rt, regs_q, wb0_live, wb0_addr, wb0_data, wb1_live, wb1_addr, wb1_data);
  end

`ifdef RF_SCOREBOARD_EN
  logic [NREG-1:0] busy_q, busy_d;

  // Clears first, then the claim, so a new producer wins over a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (wb0_en) busy_d[wb0_addr] = 1'b0;
    if (wb1_en) busy_d[wb1_addr] = 1'b0;
    if (claim_en) busy_d[claim_addr] = 1'b1;
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  logic rs_wr, rt_wr;
  assign rs_wr = (wb0_en && (wb0_addr == rs)) || (wb1_en && (wb1_addr == rs));
  assign rt_wr = (wb0_en && (wb0_addr == rt)) || (wb1_en && (wb1_addr == rt));

  always_comb begin
    rs_busy = busy_q[rs] && !(BYPASS && rs_wr);
    rt_busy = busy_q[rt] && !(BYPASS && rt_wr);
  end
`endif

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file for the datapath: two asynchronous read ports and two synchronous write-back ports, configurable data width and register count, an optional hardwired zero register and optional same-cycle write-to-read bypass. It sits between decode (read ports) and write-back (write ports). An optional compile-time scoreboard tracks registers with an outstanding producer for hazard detection in decode.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; register count NREG = 2**ADDR_W
- ZERO_REG, 1, 1: R0 reads 0 and ignores writes; 0: R0 is an ordinary register
- BYPASS, 1, 1: a read of an address written this cycle returns the write data; 0: returns the stored value

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- wb0_en  in  1  write port 0 enable
- wb0_addr  in  ADDR_W  write port 0 address
- wb0_data  in  DATA_W  write port 0 data
- wb1_en  in  1  write port 1 enable (priority port)
- wb1_addr  in  ADDR_W  write port 1 address
- wb1_data  in  DATA_W  write port 1 data
- rs  in  ADDR_W  read port A address
- rt  in  ADDR_W  read port B address
- rs_data  out  DATA_W  read port A data, combinational
- rt_data  out  DATA_W  read port B data, combinational
- claim_en  in  1  scoreboard: mark claim_addr busy (RF_SCOREBOARD_EN only)
- claim_addr  in  ADDR_W  scoreboard claim address (RF_SCOREBOARD_EN only)
- rs_busy  out  1  register rs has an outstanding producer (RF_SCOREBOARD_EN only)
- rt_busy  out  1  register rt has an outstanding producer (RF_SCOREBOARD_EN only)

## Operation
- Storage: NREG x DATA_W flops; no RAM inference required.
- Writes: on the rising edge, each enabled port writes its data to its address.
- Address collision: wb0_en and wb1_en both set with equal addresses -> wb1_data is stored.
- ZERO_REG=1: writes to address 0 are dropped. Reads of address 0 return 0 regardless of bypass.
- Read, BYPASS=0: returns the stored value R[addr].
- Read, BYPASS=1: if wb1 targets addr, returns wb1_data; else if wb0 targets addr, returns wb0_data; else returns R[addr]. Same priority as the write.
- Bypass never forwards a write to address 0 when ZERO_REG=1.
- Reset: all registers cleared to 0; reset overrides any concurrent write or claim.
- Reset is applied to the storage only. Read outputs follow the cleared state combinationally: 0 from the cycle after the reset edge, or bypassed data if a write is presented.

## Timing
- Read latency: 0 cycles; outputs are combinational in rs/rt and storage (and wb* when BYPASS=1).
- Write latency: data is visible in storage 1 cycle after the enabling edge. With BYPASS=1 it is also visible in the same cycle.
- No handshakes; write ports are always accepted.
- Output values after reset: rs_data = rt_data = 0 and rs_busy = rt_busy = 0, with no writes or claims pending.

## Configuration
- RF_SCOREBOARD_EN defined:
  - Adds an NREG-bit busy vector, cleared by reset, and the ports claim_en, claim_addr, rs_busy and rt_busy.
  - Edge with claim_en set: busy[claim_addr] is set.
  - Edge with a write: busy[wb addr] is cleared, for each enabled write port.
  - Claim and write to the same address on the same edge: the claim wins and busy stays set (new producer).
  - Address 0 is never busy when ZERO_REG=1.
  - rs_busy = busy[rs]. When BYPASS=1, rs_busy is masked low if a write to rs is presented this cycle. rt_busy follows the same rule.
- RF_SCOREBOARD_EN undefined: none of these ports or the busy state exist; the port list ends at rt_data.

## Test plan
- Reset, then read all 8 addresses on both ports -> every read returns 0x0000.
- Write 0xBEEF to R3 via wb0; next cycle rs=3 -> 0xBEEF. With BYPASS=1, rs=3 in the write cycle -> 0xBEEF. With BYPASS=0, the same read returns the old value 0x0000.
- Same cycle: wb0 writes 0x1111 and wb1 writes 0x2222, both to R5 -> stored value 0x2222, and the bypass read during that cycle also returns 0x2222.
- ZERO_REG=1: write 0xFFFF to R0 on both ports -> rs=0 reads 0x0000 in the write cycle and the cycle after.
- Assert reset and a wb1 write of 0x1234 to R2 on the same edge -> R2 reads 0x0000 afterwards.
- RF_SCOREBOARD_EN: claim R4 -> rt_busy=1 next cycle. Claim R4 and write R4 on the same edge -> busy stays 1. Write R4 alone -> rt_busy=0 the following cycle (0 in the write cycle when BYPASS=1).
